// File: rtl/vshift_seq.sv
// vshift_seq: streams one vector shift instruction through the exe-stage 64-bit SIMD shifter.
// Optional scalar shift-amount source is compiled in with `define VSHIFT_SEQ_SCALAR_EN.
package vshift_seq_pkg;
  typedef enum logic [2:0] {VSLL, VSRL, VSRA, VNSRL, VNSRA, VSSRL, VSSRA} instr_type_t;
  typedef enum logic [1:0] {SEW_8, SEW_16, SEW_32, SEW_64} sew_t;
  typedef enum logic [1:0] {VXRM_RNU, VXRM_RNE, VXRM_RDN, VXRM_ROD} vxrm_t;
endpackage

module vshift_seq
  import vshift_seq_pkg::*;
#(
  parameter int MAX_CHUNKS = 8,
  localparam int CW = $clog2(MAX_CHUNKS) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  instr_type_t   req_instr_i,
  input  sew_t          req_sew_i,
  input  vxrm_t         req_vxrm_i,
  input  logic [CW-1:0] req_nchunks_i,
`ifdef VSHIFT_SEQ_SCALAR_EN
  input  logic          req_scalar_en_i,
  input  logic [63:0]   req_scalar_i,
`endif
  input  logic          opnd_valid_i,
  output logic          opnd_ready_o,
  input  logic [63:0]   opnd_vs1_i,
  input  logic [63:0]   opnd_vs2_i,
  output instr_type_t   sh_instr_o,
  output sew_t          sh_sew_o,
  output vxrm_t         sh_vxrm_o,
  output logic [63:0]   sh_vs1_o,
  output logic [63:0]   sh_vs2_o,
  input  logic [63:0]   sh_vd_i,
  output logic          res_valid_o,
  input  logic          res_ready_i,
  output logic [63:0]   res_data_o,
  output logic [CW-2:0] res_idx_o,
  output logic          res_last_o,
  output logic          busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state;
  instr_type_t   instr_q;
  sew_t          sew_q;
  vxrm_t         vxrm_q;
  logic          narrow_q;
  logic [CW:0]   beats_q;
  logic [CW:0]   src_cnt;
  logic [CW-1:0] dst_cnt;
  logic          half_q;
  logic [31:0]   pack_lo;

  logic req_narrow;
  logic req_ok;
  logic res_fire;
  logic opnd_fire;
  logic last_beat;
  logic [63:0] vs1_sel;

`ifdef VSHIFT_SEQ_SCALAR_EN
  logic        scalar_en_q;
  logic [63:0] scalar_q;
  logic [63:0] scalar_rep;

  always_comb begin
    case (sew_q)
      SEW_8:   scalar_rep = {8{scalar_q[7:0]}};
      SEW_16:  scalar_rep = {4{scalar_q[15:0]}};
      SEW_32:  scalar_rep = {2{scalar_q[31:0]}};
      default: scalar_rep = scalar_q;
    endcase
  end
`endif

  assign req_narrow = (req_instr_i == VNSRL) || (req_instr_i == VNSRA);
  assign req_ok     = (req_nchunks_i != '0) && (req_nchunks_i <= CW'(MAX_CHUNKS));
  assign res_fire   = res_valid_o && res_ready_i;
  assign opnd_fire  = (state == ST_RUN) && !flush_i && !rst_i && opnd_valid_i
                      && (!res_valid_o || res_ready_i);
  assign last_beat  = (src_cnt == beats_q - (CW+1)'(1));

  assign req_ready_o  = (state == ST_IDLE) && !flush_i && !rst_i;
  assign opnd_ready_o = opnd_fire;
  assign busy_o       = (state != ST_IDLE);

  // The odd narrowing beat covers the upper destination elements, so it needs the upper vs1 half.
  always_comb begin
    vs1_sel = opnd_vs1_i;
    if (narrow_q && half_q) begin
      vs1_sel = {32'b0, opnd_vs1_i[63:32]};
    end
`ifdef VSHIFT_SEQ_SCALAR_EN
    if (scalar_en_q) begin
      vs1_sel = scalar_rep;
    end
`endif
  end

  assign sh_instr_o = instr_q;
  assign sh_sew_o   = sew_q;
  assign sh_vxrm_o  = vxrm_q;
  assign sh_vs1_o   = vs1_sel;
  assign sh_vs2_o   = opnd_vs2_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      instr_q     <= VSLL;
      sew_q       <= SEW_8;
      vxrm_q      <= VXRM_RNU;
      narrow_q    <= 1'b0;
      beats_q     <= '0;
      src_cnt     <= '0;
      dst_cnt     <= '0;
      half_q      <= 1'b0;
      pack_lo     <= '0;
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;
      res_idx_o   <= '0;
      res_data_o  <= '0;
`ifdef VSHIFT_SEQ_SCALAR_EN
      scalar_en_q <= 1'b0;
      scalar_q    <= '0;
`endif
    end else if (flush_i) begin
      state       <= ST_IDLE;
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;
      src_cnt     <= '0;
      dst_cnt     <= '0;
      half_q      <= 1'b0;
    end else begin
      if (res_fire) begin
        res_valid_o <= 1'b0;
        res_last_o  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ok) begin
            instr_q  <= req_instr_i;
            sew_q    <= req_sew_i;
            vxrm_q   <= req_vxrm_i;
            narrow_q <= req_narrow;
            beats_q  <= req_narrow ? {req_nchunks_i, 1'b0} : {1'b0, req_nchunks_i};
            src_cnt  <= '0;
            dst_cnt  <= '0;
            half_q   <= 1'b0;
`ifdef VSHIFT_SEQ_SCALAR_EN
            scalar_en_q <= req_scalar_en_i;
            scalar_q    <= req_scalar_i;
`endif
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (opnd_fire) begin
            if (!last_beat) begin
              src_cnt <= src_cnt + (CW+1)'(1);
            end
            if (narrow_q && !half_q) begin
              pack_lo <= sh_vd_i[31:0];
              half_q  <= 1'b1;
            end else begin
              res_valid_o <= 1'b1;
              res_data_o  <= narrow_q ? {sh_vd_i[31:0], pack_lo} : sh_vd_i;
              res_idx_o   <= dst_cnt[CW-2:0];
              res_last_o  <= last_beat;
              half_q      <= 1'b0;
              if (dst_cnt != CW'(MAX_CHUNKS - 1)) begin
                dst_cnt <= dst_cnt + CW'(1);
              end
            end
            if (last_beat) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (res_fire) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vshift_seq.sv
// tb_vshift_seq: random and directed checks of vshift_seq against a chunk-level reference model.
// A stand-in element-wise shifter drives sh_vd_i combinationally from the sh_* outputs.
module tb_vshift_seq;
  import vshift_seq_pkg::*;

  localparam int MAX_CHUNKS = 8;
  localparam int CW = $clog2(MAX_CHUNKS) + 1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  instr_type_t   req_instr;
  sew_t          req_sew;
  vxrm_t         req_vxrm;
  logic [CW-1:0] req_nchunks;
`ifdef VSHIFT_SEQ_SCALAR_EN
  logic          req_scalar_en;
  logic [63:0]   req_scalar;
`endif
  logic          opnd_valid;
  logic          opnd_ready;
  logic [63:0]   opnd_vs1;
  logic [63:0]   opnd_vs2;
  instr_type_t   sh_instr;
  sew_t          sh_sew;
  vxrm_t         sh_vxrm;
  logic [63:0]   sh_vs1;
  logic [63:0]   sh_vs2;
  logic [63:0]   sh_vd;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_data;
  logic [CW-2:0] res_idx;
  logic          res_last;
  logic          busy;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [63:0] vs1_a [MAX_CHUNKS];
  logic [63:0] vs2_a [2*MAX_CHUNKS];
  logic [63:0] got_data [MAX_CHUNKS];

  vshift_seq #(.MAX_CHUNKS(MAX_CHUNKS)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_instr_i(req_instr), .req_sew_i(req_sew), .req_vxrm_i(req_vxrm),
    .req_nchunks_i(req_nchunks),
`ifdef VSHIFT_SEQ_SCALAR_EN
    .req_scalar_en_i(req_scalar_en), .req_scalar_i(req_scalar),
`endif
    .opnd_valid_i(opnd_valid), .opnd_ready_o(opnd_ready),
    .opnd_vs1_i(opnd_vs1), .opnd_vs2_i(opnd_vs2),
    .sh_instr_o(sh_instr), .sh_sew_o(sh_sew), .sh_vxrm_o(sh_vxrm),
    .sh_vs1_o(sh_vs1), .sh_vs2_o(sh_vs2), .sh_vd_i(sh_vd),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_idx_o(res_idx), .res_last_o(res_last), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mask(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic bit isNarrow(instr_type_t op);
    return (op == VNSRL) || (op == VNSRA);
  endfunction

  // One element of width w shifted by amt, with fixed-point rounding for the scaling ops.
  function automatic logic [63:0] elemShift(instr_type_t op, vxrm_t rm, int w, logic [63:0] v, int amt);
    logic [63:0] u, r, lost;
    logic signed [63:0] s;
    logic rb;
    u = v & mask(w);
    s = $signed(u << (64 - w)) >>> (64 - w);
    case (op)
      VSLL:               r = u << amt;
      VSRL, VNSRL, VSSRL: r = u >> amt;
      default:            r = $unsigned(s >>> amt);
    endcase
    if ((op == VSSRL || op == VSSRA) && amt > 0) begin
      lost = u & ((64'd1 << amt) - 64'd1);
      case (rm)
        VXRM_RNU: rb = u[amt-1];
        VXRM_RNE: rb = u[amt-1] & (((lost & ~(64'd1 << (amt-1))) != 0) | r[0]);
        VXRM_RDN: rb = 1'b0;
        default:  rb = !r[0] & (lost != 0);
      endcase
      r = r + 64'(rb);
    end
    return r & mask(w);
  endfunction

  // Stand-in for the exe-stage shifter; narrowing yields only 32 result bits per source chunk.
  function automatic logic [63:0] shifterModel(instr_type_t op, sew_t sew, vxrm_t rm,
                                               logic [63:0] vs1, logic [63:0] vs2);
    int w, ws, n, a;
    logic [63:0] r, e;
    w  = 8 << int'(sew);
    ws = isNarrow(op) ? 2 * w : w;
    n  = isNarrow(op) ? 32 / w : 64 / w;
    r  = '0;
    for (int i = 0; i < n; i++) begin
      e = (vs2 >> (i * ws)) & mask(ws);
      a = int'(((vs1 >> (i * w)) & mask(w)) % 64'(ws));
      r = r | ((elemShift(op, rm, ws, e, a) & mask(w)) << (i * w));
    end
    return r;
  endfunction

  always_comb sh_vd = shifterModel(sh_instr, sh_sew, sh_vxrm, sh_vs1, sh_vs2);

  // Whole destination chunk j straight from the instruction semantics over the full source.
  function automatic logic [63:0] refChunk(instr_type_t op, sew_t sew, vxrm_t rm,
                                           bit scal_en, logic [63:0] scalar, int j);
    int w, ws, a;
    logic [63:0] amts, e, r;
    logic [127:0] src;
    w  = 8 << int'(sew);
    ws = isNarrow(op) ? 2 * w : w;
    amts = vs1_a[j];
    if (scal_en) begin
      amts = '0;
      for (int i = 0; i < 64 / w; i++) amts = amts | ((scalar & mask(w)) << (i * w));
    end
    src = isNarrow(op) ? {vs2_a[2*j+1], vs2_a[2*j]} : {64'b0, vs2_a[j]};
    r = '0;
    for (int i = 0; i < 64 / w; i++) begin
      e = 64'(src >> (i * ws)) & mask(ws);
      a = int'(((amts >> (i * w)) & mask(w)) % 64'(ws));
      r = r | ((elemShift(op, rm, ws, e, a) & mask(w)) << (i * w));
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 2 * MAX_CHUNKS; i++) vs2_a[i] = {$urandom, $urandom};
    for (int j = 0; j < MAX_CHUNKS; j++) vs1_a[j] = {$urandom, $urandom};
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_res_valid"}, res_valid, 1'b0);
    checkOutput({tag, "_res_last"}, res_last, 1'b0);
    checkOutput({tag, "_res_idx"}, res_idx, '0);
    checkOutput({tag, "_res_data"}, res_data, '0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_req_ready"}, req_ready, 1'b1);
    checkOutput({tag, "_opnd_ready"}, opnd_ready, 1'b0);
  endtask

  task automatic sendRequest(input instr_type_t op, input sew_t sew, input vxrm_t rm, input int n,
                             input bit scal_en, input logic [63:0] scalar);
    @(negedge clk);
    req_valid   = 1'b1;
    req_instr   = op;
    req_sew     = sew;
    req_vxrm    = rm;
    req_nchunks = CW'(n);
`ifdef VSHIFT_SEQ_SCALAR_EN
    req_scalar_en = scal_en;
    req_scalar    = scalar;
`endif
    #1;
    checkOutput("req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Runs one full instruction using vs1_a/vs2_a and checks every result and its timing.
  task automatic applyStimulus(input instr_type_t op, input sew_t sew, input vxrm_t rm, input int n,
                               input int valid_pct, input int ready_pct, input int stall_first,
                               input bit scal_en, input logic [63:0] scalar);
    int beats, beat, got, stall;
    bit narrow, prev_emit, prev_hold;
    logic [63:0] prev_data;
    logic [63:0] exp_data [MAX_CHUNKS];
    narrow = isNarrow(op);
    beats  = narrow ? 2 * n : n;
    for (int j = 0; j < n; j++) exp_data[j] = refChunk(op, sew, rm, scal_en, scalar, j);
    sendRequest(op, sew, rm, n, scal_en, scalar);
    beat = 0; got = 0; stall = stall_first;
    prev_emit = 0; prev_hold = 0; prev_data = '0;
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      opnd_valid = (beat < beats) && ($urandom_range(99) < valid_pct);
      opnd_vs2   = (beat < beats) ? vs2_a[beat] : {$urandom, $urandom};
      opnd_vs1   = (beat < beats) ? vs1_a[narrow ? beat / 2 : beat] : {$urandom, $urandom};
      if (stall > 0 && res_valid) begin
        res_ready = 1'b0;
        stall--;
      end else begin
        res_ready = ($urandom_range(99) < ready_pct);
      end
      #1;
      if (prev_emit) checkOutput("latency", res_valid, 1'b1);
      if (prev_hold) begin
        checkOutput("hold_valid", res_valid, 1'b1);
        checkOutput("hold_data", res_data, prev_data);
      end
      if (res_valid && !res_ready && opnd_valid) checkOutput("opnd_block", opnd_ready, 1'b0);
      if (res_valid && res_ready) begin
        checkOutput("res_data", res_data, exp_data[got]);
        checkOutput("res_idx", res_idx, 64'(got));
        checkOutput("res_last", res_last, (got == n - 1));
        got_data[got] = res_data;
        got++;
      end
      prev_emit = opnd_valid && opnd_ready && (!narrow || (beat % 2 == 1));
      prev_hold = res_valid && !res_ready;
      prev_data = res_data;
      if (opnd_valid && opnd_ready) beat++;
      @(negedge clk);
    end
    opnd_valid = 1'b0;
    res_ready  = 1'b1;
    #1;
    checkOutput("results_seen", 64'(got), 64'(n));
    checkOutput("beats_used", 64'(beat), 64'(beats));
    checkOutput("busy_end", busy, 1'b0);
    checkOutput("valid_end", res_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d expected finish", n_compared);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    instr_type_t op;
    sew_t sew;
    int n;
    bit scal_en;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_instr = VSLL; req_sew = SEW_8;
    req_vxrm = VXRM_RNU; req_nchunks = '0; opnd_valid = 1'b0; opnd_vs1 = '0; opnd_vs2 = '0;
    res_ready = 1'b1;
`ifdef VSHIFT_SEQ_SCALAR_EN
    req_scalar_en = 1'b0; req_scalar = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    opnd_valid = 1'b1;
    #1;
    checkResetValues("reset");
    opnd_valid = 1'b0;

    $display("[TB] VSRL SEW_8 directed");
    fillRandom();
    vs2_a[0] = 64'h8080_8080_8080_8080; vs2_a[1] = 64'h8080_8080_8080_8080;
    vs1_a[0] = 64'h0101_0101_0101_0101; vs1_a[1] = 64'h0101_0101_0101_0101;
    applyStimulus(VSRL, SEW_8, VXRM_RNU, 2, 100, 100, 0, 1'b0, '0);
    checkOutput("vsrl_c0", got_data[0], 64'h4040_4040_4040_4040);
    checkOutput("vsrl_c1", got_data[1], 64'h4040_4040_4040_4040);

    $display("[TB] VNSRA SEW_16 directed");
    vs2_a[0] = 64'hFFFF_0000_8000_0000; vs2_a[1] = 64'h0;
    vs1_a[0] = 64'h0010_0010_0010_0010;
    applyStimulus(VNSRA, SEW_16, VXRM_RNU, 1, 100, 100, 0, 1'b0, '0);
    checkOutput("vnsra_c0", got_data[0], 64'h0000_0000_FFFF_8000);

    $display("[TB] VSSRL SEW_32 with writeback stall");
    fillRandom();
    applyStimulus(VSSRL, SEW_32, VXRM_RNE, 2, 100, 100, 3, 1'b0, '0);

    $display("[TB] flush mid-instruction");
    fillRandom();
    sendRequest(VSLL, SEW_8, VXRM_RNU, 4, 1'b0, '0);
    opnd_valid = 1'b1; opnd_vs1 = vs1_a[0]; opnd_vs2 = vs2_a[0]; res_ready = 1'b1;
    #1;
    checkOutput("flush_beat0_ready", opnd_ready, 1'b1);
    @(negedge clk);
    flush = 1'b1; res_ready = 1'b0; opnd_vs1 = vs1_a[1]; opnd_vs2 = vs2_a[1];
    #1;
    checkOutput("flush_opnd_ready", opnd_ready, 1'b0);
    checkOutput("flush_req_ready", req_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; opnd_valid = 1'b0; res_ready = 1'b1;
    #1;
    checkOutput("flush_res_valid", res_valid, 1'b0);
    checkOutput("flush_busy", busy, 1'b0);
    checkOutput("flush_req_ready_after", req_ready, 1'b1);
    fillRandom();
    applyStimulus(VSRA, SEW_16, VXRM_RNU, 4, 100, 100, 0, 1'b0, '0);

    $display("[TB] out-of-range chunk counts");
    for (int k = 0; k < 2; k++) begin
      sendRequest(VSLL, SEW_8, VXRM_RNU, (k == 0) ? 0 : MAX_CHUNKS + 1, 1'b0, '0);
      opnd_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        #1;
        checkOutput("drop_busy", busy, 1'b0);
        checkOutput("drop_res_valid", res_valid, 1'b0);
        checkOutput("drop_opnd_ready", opnd_ready, 1'b0);
        @(negedge clk);
      end
      opnd_valid = 1'b0;
    end

    $display("[TB] reset during RUN");
    fillRandom();
    sendRequest(VSRL, SEW_32, VXRM_RNU, 3, 1'b0, '0);
    opnd_valid = 1'b1; opnd_vs1 = vs1_a[0]; opnd_vs2 = vs2_a[0]; res_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetValues("midrst");
    opnd_valid = 1'b0; res_ready = 1'b1;

`ifdef VSHIFT_SEQ_SCALAR_EN
    $display("[TB] scalar shift amount");
    fillRandom();
    vs2_a[0] = 64'h0101_0101_0101_0101; vs2_a[1] = 64'h0101_0101_0101_0101;
    applyStimulus(VSLL, SEW_8, VXRM_RNU, 2, 100, 100, 0, 1'b1, 64'd3);
    checkOutput("scalar_c0", got_data[0], 64'h0808_0808_0808_0808);
    checkOutput("scalar_c1", got_data[1], 64'h0808_0808_0808_0808);
`endif

    $display("[TB] randomized instructions");
    for (int t = 0; t < 30; t++) begin
      op  = instr_type_t'($urandom_range(6));
      sew = sew_t'(isNarrow(op) ? $urandom_range(2) : $urandom_range(3));
      n   = $urandom_range(1, MAX_CHUNKS);
      scal_en = 1'b0;
`ifdef VSHIFT_SEQ_SCALAR_EN
      scal_en = $urandom_range(1) == 1;
`endif
      fillRandom();
      applyStimulus(op, sew, vxrm_t'($urandom_range(3)), n, $urandom_range(40, 100),
                    $urandom_range(40, 100), $urandom_range(2), scal_en, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
